esm_dep_tracker: RTL and testbench
==================================

Name: esm_dep_tracker

Overview:
- Parametrised next-generation dependency analyser for the ESM instruction buffer.
- Owns allocation of buffer slots, a full bs x bs dependency matrix, selectable hazard classes (RAW/WAW/WAR), lowest-index issue selection with handshake, and completion-driven dependency release.
- Sits between decode and the execution units; replaces externally supplied buffer_index/valid_entries with internally tracked state.

Parameters:
- Instruction_word_size, 32, instruction width; rd=[11:7], rs1=[19:15], rs2=[24:20].
- bs, 16, buffer depth (power of two, >=2).
- regnum, 32, architectural register count; register 0 never creates a dependency.
- TRACK_WAW, 1, 1 = a new rd matching an older rd creates a dependency.
- TRACK_WAR, 1, 1 = a new rd matching an older rs1/rs2 creates a dependency.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous clear of all entries.
- alloc_valid, in, 1, decode presents an instruction.
- alloc_ready, out, 1, at least one free slot.
- RegWrite, in, 1, instruction writes rd.
- ALUSrc, in, 1, 1 = immediate operand, so rs2 is unused.
- Instr_in, in, Instruction_word_size, instruction word.
- alloc_index, out, $clog2(bs), slot assigned when the handshake fires.
- issue_valid, out, 1, an independent, unissued entry exists.
- issue_ready, in, 1, execution unit accepts.
- issue_index, out, $clog2(bs), selected entry.
- complete_valid, in, 1, an entry has finished.
- complete_index, in, $clog2(bs), finished entry.
- valid_entries, out, [0:bs-1], occupied slots.
- independent_instr, out, [0:bs-1], valid entries with an all-zero dependency row.
- occupancy, out, $clog2(bs)+1, count of valid entries.
- err, out, 1, sticky: completion of an invalid or unissued entry.

Behaviour:
- Reset (rst=0, asynchronous): valid, issued, dependency matrix, stored rd/rs1/rs2/wr, and err all clear.
  - Resulting outputs: alloc_ready=1, issue_valid=0, alloc_index=0, occupancy=0.
  - Reset asserted mid-operation discards all entries immediately.
- Field decode: rd=0 when RegWrite=0; rs2=0 when ALUSrc=1.
- Allocation:
  - alloc_ready = ~&valid (registered state only).
  - alloc_index = lowest free slot.
  - On alloc_valid&alloc_ready at edge N: slot gets valid=1, issued=0, stored fields, and its dependency row.
- Dependency row, bit j set if slot j is valid, not completing this cycle, and any of:
  - RAW: new rs1 or rs2 == rd_j, with rd_j != 0.
  - WAW (if TRACK_WAW): new rd == rd_j, with new rd != 0.
  - WAR (if TRACK_WAR): new rd == rs1_j or rs2_j, with new rd != 0.
- Timing: a dependent entry appears in valid_entries after edge N, but not in independent_instr. An independent entry appears in both after edge N (1-cycle latency).
- Issue:
  - candidates = independent & ~issued.
  - issue_valid = |candidates; issue_index = lowest candidate; both combinational from registered state.
  - On issue_valid&issue_ready the entry is marked issued; it stays valid.
  - issue_index is held stable while issue_valid=1 and issue_ready=0, unless a lower-index candidate appears.
- Completion:
  - On complete_valid for a valid, issued slot j: valid_j=0, issued_j=0, and column j cleared in every row at the next edge.
  - Otherwise: no state change and err=1, sticky until reset.
- Simultaneous events:
  - Alloc and complete in the same cycle: the freed slot is not reusable until the next cycle, and the new row excludes the completing slot.
  - Issue and complete of the same slot in the same cycle: completion rule applies to pre-edge state, so an unissued slot raises err.
- flush: clears valid, issued, and matrix at the next edge. It has priority over alloc, issue and complete in the same cycle. err is unaffected.
- occupancy: popcount of valid.

Test Plan:
- Reset, then alloc "add x3,x1,x2" (RegWrite=1, ALUSrc=0) -> alloc_index=0; next cycle valid_entries bit0=1, independent_instr bit0=1, issue_valid=1, issue_index=0.
- Slot0 writes x3, then alloc "add x4,x3,x5" -> slot1 dependent (RAW), independent_instr bit1=0. Issue and complete slot0 -> one cycle later independent_instr bit1=1.
- TRACK_WAW=0, TRACK_WAR=0: slot0 "add x3,x1,x2", then slot1 "addi x1,x6,4" (ALUSrc=1) -> slot1 independent. Repeat with TRACK_WAR=1 -> slot1 dependent on slot0.
- Fill all bs=16 slots -> alloc_ready=0, occupancy=16. Complete slot 5 in the same cycle as alloc_valid=1 -> no allocation that cycle; next cycle alloc_index=5.
- complete_index=7 while slot7 is empty -> err=1 and stays 1; valid_entries unchanged.
- Assert rst low mid-stream with 6 entries valid -> all outputs return to reset values without waiting for a clock edge. Separately, flush=1 with a concurrent alloc -> occupancy=0 next cycle.

Source files
------------

// File: rtl/esm_dep_tracker.sv
// Instruction-buffer dependency tracker: allocates slots, records a bs x bs hazard
// matrix at allocation, selects the lowest independent unissued slot, releases on completion.
module esm_dep_tracker #(
   parameter int Instruction_word_size = 32,
   parameter int bs                    = 16,
   parameter int regnum                = 32,
   parameter bit TRACK_WAW             = 1'b1,
   parameter bit TRACK_WAR             = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic                             alloc_valid,
   output logic                             alloc_ready,
   input  logic                             RegWrite,
   input  logic                             ALUSrc,
   input  logic [Instruction_word_size-1:0] Instr_in,
   output logic [$clog2(bs)-1:0]            alloc_index,
   output logic                             issue_valid,
   input  logic                             issue_ready,
   output logic [$clog2(bs)-1:0]            issue_index,
   input  logic                             complete_valid,
   input  logic [$clog2(bs)-1:0]            complete_index,
   output logic [0:bs-1]                    valid_entries,
   output logic [0:bs-1]                    independent_instr,
   output logic [$clog2(bs):0]              occupancy,
   output logic                             err
);

   localparam int IW = $clog2(bs);
   localparam int RW = $clog2(regnum);

   logic [bs-1:0]          valid_q;
   logic [bs-1:0]          issued_q;
   logic [bs-1:0][bs-1:0]  dep_q;
   logic [bs-1:0][RW-1:0]  rd_q;
   logic [bs-1:0][RW-1:0]  rs1_q;
   logic [bs-1:0][RW-1:0]  rs2_q;
   logic                   err_q;

   logic [RW-1:0]          rd_new;
   logic [RW-1:0]          rs1_new;
   logic [RW-1:0]          rs2_new;
   logic [bs-1:0]          indep;
   logic [bs-1:0]          cand;
   logic [bs-1:0]          comp_mask;
   logic [bs-1:0]          new_row;
   logic                   comp_ok;
   logic                   alloc_fire;
   logic                   issue_fire;
   logic                   comp_fire;
   logic                   err_set;
   logic                   unused_instr;

   // Only the register fields are consumed; the rest of the word is ignored here.
   assign unused_instr = ^Instr_in;

   assign rd_new  = RegWrite ? Instr_in[7 +: RW] : '0;
   assign rs1_new = Instr_in[15 +: RW];
   assign rs2_new = ALUSrc ? '0 : Instr_in[20 +: RW];

   always_comb begin
      for (int i = 0; i < bs; i++) begin
         indep[i] = valid_q[i] & ~(|dep_q[i]);
      end
   end

   assign cand        = indep & ~issued_q;
   assign alloc_ready = ~(&valid_q);
   assign issue_valid = |cand;

   // Descending scans so the lowest matching index is the one left standing.
   always_comb begin
      alloc_index = '0;
      for (int i = bs - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_index = IW'(i);
      end
   end

   always_comb begin
      issue_index = '0;
      for (int i = bs - 1; i >= 0; i--) begin
         if (cand[i]) issue_index = IW'(i);
      end
   end

   always_comb begin
      valid_entries     = '0;
      independent_instr = '0;
      occupancy         = '0;
      for (int i = 0; i < bs; i++) begin
         valid_entries[i]     = valid_q[i];
         independent_instr[i] = indep[i];
         occupancy            = occupancy + {{IW{1'b0}}, valid_q[i]};
      end
   end

   assign comp_ok    = complete_valid & valid_q[complete_index] & issued_q[complete_index];
   assign alloc_fire = alloc_valid & alloc_ready & ~flush;
   assign issue_fire = issue_valid & issue_ready & ~flush;
   assign comp_fire  = comp_ok & ~flush;
   assign err_set    = complete_valid & ~comp_ok & ~flush;
   assign err        = err_q;

   // A slot retiring this cycle must not become a producer for the new entry.
   always_comb begin
      comp_mask = '0;
      if (comp_ok) comp_mask[complete_index] = 1'b1;
   end

   always_comb begin
      new_row = '0;
      for (int j = 0; j < bs; j++) begin
         new_row[j] = valid_q[j] & ~comp_mask[j] &
                      (((rd_q[j] != '0) && ((rs1_new == rd_q[j]) || (rs2_new == rd_q[j]))) ||
                       (TRACK_WAW && (rd_new != '0) && (rd_new == rd_q[j])) ||
                       (TRACK_WAR && (rd_new != '0) &&
                        ((rd_new == rs1_q[j]) || (rd_new == rs2_q[j]))));
      end
   end

   // Issue, completion and allocation always touch distinct slots, so their
   // updates cannot collide; the new row already excludes the completing column.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q  <= '0;
         issued_q <= '0;
         dep_q    <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
      end else if (flush) begin
         valid_q  <= '0;
         issued_q <= '0;
         dep_q    <= '0;
      end else begin
         if (issue_fire) issued_q[issue_index] <= 1'b1;
         if (comp_fire) begin
            valid_q[complete_index]  <= 1'b0;
            issued_q[complete_index] <= 1'b0;
            for (int i = 0; i < bs; i++) begin
               dep_q[i][complete_index] <= 1'b0;
            end
         end
         if (alloc_fire) begin
            valid_q[alloc_index]  <= 1'b1;
            issued_q[alloc_index] <= 1'b0;
            dep_q[alloc_index]    <= new_row;
            rd_q[alloc_index]     <= rd_new;
            rs1_q[alloc_index]    <= rs1_new;
            rs2_q[alloc_index]    <= rs2_new;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_esm_dep_tracker.sv
// Bench for esm_dep_tracker: two instances (all hazards / RAW only) driven in lockstep
// and compared against a slot-level reference model, a directed table and corner sequences.
module tb_esm_dep_tracker;

   localparam int BS = 16;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        alloc_valid;
   logic        RegWrite;
   logic        ALUSrc;
   logic [31:0] Instr_in;
   logic        issue_ready;
   logic        complete_valid;
   logic [3:0]  complete_index;

   logic        a_alloc_ready, b_alloc_ready;
   logic [3:0]  a_alloc_index, b_alloc_index;
   logic        a_issue_valid, b_issue_valid;
   logic [3:0]  a_issue_index, b_issue_index;
   logic [0:BS-1] a_valid_entries, b_valid_entries;
   logic [0:BS-1] a_independent, b_independent;
   logic [4:0]  a_occupancy, b_occupancy;
   logic        a_err, b_err;

   logic [BS-1:0] a_valid_s, b_valid_s, a_ind_s, b_ind_s;

   int n_checks;
   int n_pass;

   esm_dep_tracker #(.bs(BS)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .alloc_valid(alloc_valid),
      .alloc_ready(a_alloc_ready), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
      .Instr_in(Instr_in), .alloc_index(a_alloc_index), .issue_valid(a_issue_valid),
      .issue_ready(issue_ready), .issue_index(a_issue_index),
      .complete_valid(complete_valid), .complete_index(complete_index),
      .valid_entries(a_valid_entries), .independent_instr(a_independent),
      .occupancy(a_occupancy), .err(a_err)
   );

   esm_dep_tracker #(.bs(BS), .TRACK_WAW(1'b0), .TRACK_WAR(1'b0)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .alloc_valid(alloc_valid),
      .alloc_ready(b_alloc_ready), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
      .Instr_in(Instr_in), .alloc_index(b_alloc_index), .issue_valid(b_issue_valid),
      .issue_ready(issue_ready), .issue_index(b_issue_index),
      .complete_valid(complete_valid), .complete_index(complete_index),
      .valid_entries(b_valid_entries), .independent_instr(b_independent),
      .occupancy(b_occupancy), .err(b_err)
   );

   // Re-index the [0:BS-1] outputs so bit i is slot i.
   always_comb begin
      for (int i = 0; i < BS; i++) begin
         a_valid_s[i] = a_valid_entries[i];
         b_valid_s[i] = b_valid_entries[i];
         a_ind_s[i]   = a_independent[i];
         b_ind_s[i]   = b_independent[i];
      end
   end

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (per instance) ----------------
   bit m_v   [2][BS];
   bit m_iss [2][BS];
   bit m_dep [2][BS][BS];
   int m_rd  [2][BS];
   int m_rs1 [2][BS];
   int m_rs2 [2][BS];
   bit m_err [2];
   bit m_waw [2] = '{1'b1, 1'b0};
   bit m_war [2] = '{1'b1, 1'b0};

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_err[m] = 1'b0;
         for (int i = 0; i < BS; i++) begin
            m_v[m][i] = 1'b0; m_iss[m][i] = 1'b0;
            m_rd[m][i] = 0; m_rs1[m][i] = 0; m_rs2[m][i] = 0;
            for (int j = 0; j < BS; j++) m_dep[m][i][j] = 1'b0;
         end
      end
   endtask

   function automatic bit m_indep(int m, int i);
      bit waits;
      waits = 1'b0;
      for (int j = 0; j < BS; j++) if (m_dep[m][i][j]) waits = 1'b1;
      return m_v[m][i] && !waits;
   endfunction

   function automatic int m_free(int m);
      for (int i = 0; i < BS; i++) if (!m_v[m][i]) return i;
      return -1;
   endfunction

   function automatic int m_cand(int m);
      for (int i = 0; i < BS; i++) if (m_indep(m, i) && !m_iss[m][i]) return i;
      return -1;
   endfunction

   task automatic model_step(int m);
      int  ai, ii, ci, nrd, nrs1, nrs2;
      bit  comp_ok;
      bit  row [BS];
      if (flush) begin
         for (int i = 0; i < BS; i++) begin
            m_v[m][i] = 1'b0; m_iss[m][i] = 1'b0;
            for (int j = 0; j < BS; j++) m_dep[m][i][j] = 1'b0;
         end
         return;
      end
      ai = m_free(m);
      ii = m_cand(m);
      ci = int'(complete_index);
      comp_ok = complete_valid && m_v[m][ci] && m_iss[m][ci];
      if (complete_valid && !comp_ok) m_err[m] = 1'b1;
      nrd  = RegWrite ? int'(Instr_in[11:7]) : 0;
      nrs1 = int'(Instr_in[19:15]);
      nrs2 = ALUSrc ? 0 : int'(Instr_in[24:20]);
      for (int j = 0; j < BS; j++) begin
         row[j] = m_v[m][j] && !(comp_ok && j == ci) &&
                  ((m_rd[m][j] != 0 && (nrs1 == m_rd[m][j] || nrs2 == m_rd[m][j])) ||
                   (m_waw[m] && nrd != 0 && nrd == m_rd[m][j]) ||
                   (m_war[m] && nrd != 0 && (nrd == m_rs1[m][j] || nrd == m_rs2[m][j])));
      end
      if (ii >= 0 && issue_ready) m_iss[m][ii] = 1'b1;
      if (comp_ok) begin
         m_v[m][ci] = 1'b0; m_iss[m][ci] = 1'b0;
         for (int r = 0; r < BS; r++) m_dep[m][r][ci] = 1'b0;
      end
      if (alloc_valid && ai >= 0) begin
         m_v[m][ai] = 1'b1; m_iss[m][ai] = 1'b0;
         m_rd[m][ai] = nrd; m_rs1[m][ai] = nrs1; m_rs2[m][ai] = nrs2;
         for (int j = 0; j < BS; j++) m_dep[m][ai][j] = row[j];
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [3:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic check_inst(input int m, input logic rdy, input logic [3:0] aidx,
                             input logic iv, input logic [3:0] iidx, input logic [15:0] ve,
                             input logic [15:0] ind, input logic [4:0] occ, input logic e);
      logic [15:0] eve, eind;
      int          cnt, fr, cd;
      eve = '0; eind = '0; cnt = 0;
      for (int i = 0; i < BS; i++) begin
         eve[i]  = m_v[m][i];
         eind[i] = m_indep(m, i);
         cnt    += int'(m_v[m][i]);
      end
      fr = m_free(m);
      cd = m_cand(m);
      chk($sformatf("i%0d alloc_ready", m), 32'(rdy), 32'(fr >= 0));
      if (fr >= 0) chk($sformatf("i%0d alloc_index", m), 32'(aidx), 32'(fr));
      chk($sformatf("i%0d issue_valid", m), 32'(iv), 32'(cd >= 0));
      if (cd >= 0) chk($sformatf("i%0d issue_index", m), 32'(iidx), 32'(cd));
      chk($sformatf("i%0d valid_entries", m), 32'(ve), 32'(eve));
      chk($sformatf("i%0d independent", m), 32'(ind), 32'(eind));
      chk($sformatf("i%0d occupancy", m), 32'(occ), 32'(cnt));
      chk($sformatf("i%0d err", m), 32'(e), 32'(m_err[m]));
   endtask

   task automatic check_all();
      check_inst(0, a_alloc_ready, a_alloc_index, a_issue_valid, a_issue_index,
                 a_valid_s, a_ind_s, a_occupancy, a_err);
      check_inst(1, b_alloc_ready, b_alloc_index, b_issue_valid, b_issue_index,
                 b_valid_s, b_ind_s, b_occupancy, b_err);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      flush = 1'b0; alloc_valid = 1'b0; RegWrite = 1'b0; ALUSrc = 1'b0;
      Instr_in = '0; issue_ready = 1'b0; complete_valid = 1'b0; complete_index = '0;
   endtask

   // Inputs are set at the negedge; the model advances on the posedge, outputs are checked at the next negedge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_step(0);
         model_step(1);
      end
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [31:0] r_type(int rd, int rs1, int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] i_type(int rd, int rs1, int imm);
      return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13};
   endfunction

   task automatic do_alloc(input logic rw, input logic src, input logic [31:0] ins);
      alloc_valid = 1'b1; RegWrite = rw; ALUSrc = src; Instr_in = ins;
      tick();
      idle_inputs();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        av, rw, src, ir, cv, fl;
      logic [31:0] ins;
      logic [3:0]  ci;
      logic [15:0] e_valid, e_ind_a, e_ind_b;
      logic        e_iv;
      logic [3:0]  e_ii;
      logic [4:0]  e_occ;
   } vec_t;

   vec_t vecs[9];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      model_reset();
      idle_inputs();
      rst = 1'b0;

      //            av  rw  src ir  cv  fl  instr             ci  valid    indA     indB     iv  ii  occ
      vecs[0] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, r_type(3,1,2), 4'd0, 16'h0001,16'h0001,16'h0001,1'b1,4'd0,5'd1};
      vecs[1] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, r_type(4,3,5), 4'd0, 16'h0003,16'h0001,16'h0001,1'b1,4'd0,5'd2};
      vecs[2] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'd0,         4'd0, 16'h0003,16'h0001,16'h0001,1'b0,4'd0,5'd2};
      vecs[3] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'd0,         4'd0, 16'h0002,16'h0002,16'h0002,1'b1,4'd1,5'd1};
      vecs[4] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'd0,         4'd0, 16'h0002,16'h0002,16'h0002,1'b0,4'd0,5'd1};
      vecs[5] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'd0,         4'd1, 16'h0000,16'h0000,16'h0000,1'b0,4'd0,5'd0};
      vecs[6] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, r_type(3,1,2), 4'd0, 16'h0001,16'h0001,16'h0001,1'b1,4'd0,5'd1};
      // addi x1,x6,3: imm bits overlap rs2 (=3) but ALUSrc masks it; WAR on x1 only in instance a.
      vecs[7] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, i_type(1,6,3), 4'd0, 16'h0003,16'h0001,16'h0003,1'b1,4'd0,5'd2};
      vecs[8] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, r_type(5,5,5), 4'd0, 16'h0000,16'h0000,16'h0000,1'b0,4'd0,5'd0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset alloc_ready", 32'(a_alloc_ready), 32'd1);
      chk("reset alloc_index", 32'(a_alloc_index), 32'd0);
      chk("reset issue_valid", 32'(a_issue_valid), 32'd0);
      chk("reset occupancy", 32'(a_occupancy), 32'd0);
      check_all();
      rst = 1'b1;
      tick();

      // Directed table
      for (int v = 0; v < 9; v++) begin
         alloc_valid = vecs[v].av; RegWrite = vecs[v].rw; ALUSrc = vecs[v].src;
         issue_ready = vecs[v].ir; complete_valid = vecs[v].cv; flush = vecs[v].fl;
         Instr_in = vecs[v].ins; complete_index = vecs[v].ci;
         tick();
         chk($sformatf("vec%0d valid", v), 32'(a_valid_s), 32'(vecs[v].e_valid));
         chk($sformatf("vec%0d indep_a", v), 32'(a_ind_s), 32'(vecs[v].e_ind_a));
         chk($sformatf("vec%0d indep_b", v), 32'(b_ind_s), 32'(vecs[v].e_ind_b));
         chk($sformatf("vec%0d issue_valid", v), 32'(a_issue_valid), 32'(vecs[v].e_iv));
         if (vecs[v].e_iv) chk($sformatf("vec%0d issue_index", v), 32'(a_issue_index), 32'(vecs[v].e_ii));
         chk($sformatf("vec%0d occupancy", v), 32'(a_occupancy), 32'(vecs[v].e_occ));
         idle_inputs();
      end

      // Fill all slots, then complete slot 5 alongside a blocked allocation
      for (int k = 0; k < BS; k++) do_alloc(1'b0, 1'b0, $urandom);
      chk("full alloc_ready", 32'(a_alloc_ready), 32'd0);
      chk("full occupancy", 32'(a_occupancy), 32'd16);
      for (int k = 0; k < 6; k++) exp_q.push_back(4'(k));
      while (exp_q.size() > 0) begin
         chk("fill issue_index", 32'(a_issue_index), 32'(exp_q.pop_front()));
         issue_ready = 1'b1;
         tick();
         idle_inputs();
      end
      alloc_valid = 1'b1; Instr_in = r_type(9, 9, 9); RegWrite = 1'b1;
      complete_valid = 1'b1; complete_index = 4'd5;
      tick();
      idle_inputs();
      chk("freed occupancy", 32'(a_occupancy), 32'd15);
      chk("freed alloc_ready", 32'(a_alloc_ready), 32'd1);
      chk("freed alloc_index", 32'(a_alloc_index), 32'd5);
      do_alloc(1'b1, 1'b0, r_type(9, 9, 9));
      chk("refill slot5", 32'(a_valid_s[5]), 32'd1);
      chk("refill occupancy", 32'(a_occupancy), 32'd16);
      flush = 1'b1;
      tick();
      idle_inputs();

      // Randomised traffic; completions target slots issued in both instances
      for (int c = 0; c < 400; c++) begin
         int picks[$];
         alloc_valid = ($urandom_range(0, 9) < 7);
         RegWrite    = $urandom_range(0, 1);
         ALUSrc      = $urandom_range(0, 1);
         Instr_in    = r_type($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
         issue_ready = ($urandom_range(0, 9) < 6);
         flush       = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < BS; i++) if (m_iss[0][i] && m_iss[1][i]) picks.push_back(i);
         if (picks.size() > 0 && $urandom_range(0, 1) == 1) begin
            complete_valid = 1'b1;
            complete_index = 4'(picks[$urandom_range(0, picks.size() - 1)]);
         end
         tick();
         idle_inputs();
      end
      flush = 1'b1;
      tick();
      idle_inputs();

      // Completion of an empty slot raises a sticky err that flush leaves alone
      complete_valid = 1'b1; complete_index = 4'd7;
      tick();
      idle_inputs();
      chk("err set", 32'(a_err), 32'd1);
      chk("err valid unchanged", 32'(a_valid_s), 32'd0);
      flush = 1'b1;
      tick();
      idle_inputs();
      tick();
      chk("err sticky", 32'(a_err), 32'd1);

      // Asynchronous reset mid-stream with 6 entries
      for (int k = 0; k < 6; k++) do_alloc(1'b1, 1'b0, r_type(k + 1, k, k + 2));
      chk("pre-reset occupancy", 32'(a_occupancy), 32'd6);
      #2 rst = 1'b0;
      #1;
      chk("async alloc_ready", 32'(a_alloc_ready), 32'd1);
      chk("async alloc_index", 32'(a_alloc_index), 32'd0);
      chk("async issue_valid", 32'(a_issue_valid), 32'd0);
      chk("async occupancy", 32'(a_occupancy), 32'd0);
      chk("async valid", 32'(a_valid_s), 32'd0);
      chk("async err", 32'(a_err), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      tick();
      do_alloc(1'b1, 1'b0, r_type(3, 1, 2));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
